boothmul_arbiter: RTL
=====================

# boothmul_arbiter

Round-robin arbiter and sequencer that lets up to four requesters share one combinational 8x8 signed Booth multiplier (`boothmul`). It captures the winning requester's operands into registers and drives the shared `boothmul` instance from them. It returns a registered 16-bit signed product tagged with the requester ID. The block sits between the multiplier datapath and its client blocks, so only one `boothmul` instance is needed.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters; legal values are 2..4.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous and active-high.
- `req`  in  N_REQ  per-requester request level.
- `a_in`  in  8*N_REQ  signed multiplicand, flattened; requester i uses bits [8i+7:8i].
- `b_in`  in  8*N_REQ  signed multiplier, flattened, same packing as `a_in`.
- `grant`  out  N_REQ  one-hot; registered pulse, high for exactly one cycle when requester i's operands were captured.
- `busy`  out  1  high while a multiply is in flight (CALC state).
- `res_valid`  out  1  one-cycle pulse; `res` and `res_id` are valid while it is high.
- `res`  out  16  signed product a*b, two's complement.
- `res_id`  out  2  index of the requester that owns `res`.

## Operation
- FSM states:
  - IDLE (reset state).
  - CALC.
  - DONE.
- Arbitration runs only in IDLE and DONE. In those states, if any `req` bit is set:
  - Select the winner by round-robin. The search starts at `last+1` (mod N_REQ), where `last` is the most recently granted index. `last` resets to N_REQ-1, so requester 0 has first priority after reset.
  - At the clock edge: latch the winner's a/b into `op_a`/`op_b`, set `grant[winner]`, store the winner in `last` and `cur_id`, and go to CALC.
- If no request is present: IDLE stays in IDLE, and DONE returns to IDLE.
- CALC:
  - `boothmul` is driven from `op_a`/`op_b` and `busy`=1.
  - At the edge: `res` <= product, `res_id` <= `cur_id`, `res_valid` <= 1, go to DONE.
  - `req` is ignored in this state.
- DONE:
  - `res_valid` is high and arbitration runs, allowing back-to-back operation.
- Requester protocol:
  - Hold `req`, `a_in` and `b_in` stable until `grant` is seen.
  - Deassert `req` in the `grant` cycle (CALC). A `req` still high in the following IDLE/DONE cycle counts as a new request.
  - `a_in`/`b_in` may change freely after `grant`.
- Arithmetic:
  - Full signed 8x8 -> 16 product; no truncation or saturation.
  - -128 * -128 = +16384 fits.
- Reset (any time, including mid-operation):
  - `grant`=0, `busy`=0, `res_valid`=0, `res`=0, `res_id`=0.
  - State=IDLE, `last`=N_REQ-1, operand registers = 0.
  - An in-flight operation is discarded; no `res_valid` is produced for it.
- Requests on indices >= N_REQ do not exist; `res_id` upper bits are 0 when N_REQ=2.

## Timing
- Cycle n: `req` sampled in IDLE/DONE.
- Cycle n+1: `grant` high, `busy` high (CALC).
- Cycle n+2: `res_valid` high with the result (DONE).
- Latency is 2 cycles from the request-sample cycle to `res_valid`.
- Sustained throughput is one product every 2 cycles. `grant` pulses and `res_valid` pulses alternate cycles under continuous load.
- `grant`, `res_valid`, `res`, `res_id` and `busy` are all registered outputs; there are no combinational paths from inputs to outputs.
- `res`/`res_id` hold their last value after `res_valid` drops.

## Test plan
1. Single request:
   - Stimulus: after reset, `req`=0001, a0=-82 (8'hAE), b0=39.
   - Required response: `grant`=0001 one cycle later, then `res_valid` with `res`=16'hF382 (-3198) and `res_id`=0.
2. All four requesting from reset, each holding until granted (a_i/b_i = -16/-48, -99/16, 7/101, 28/5):
   - Grants in order 0, 1, 2, 3, two cycles apart.
   - Results 768, -1584, 707, 140 with matching `res_id`.
3. Fairness:
   - Stimulus: the last grant went to 2; requesters 1 and 3 then request in the same cycle.
   - Required response: 3 is granted first, then 1.
4. Corner values:
   - -128*-128 -> 16'h4000.
   - -128*127 -> 16'hC080.
   - 127*127 -> 16'h3F01.
   - 0*-1 -> 0.
5. Reset in CALC:
   - Stimulus: assert `rst` while `busy`=1.
   - Required response: all outputs go to 0 immediately and `res_valid` never pulses for that operation.
   - After release, `req`=1010 grants requester 1 first.
6. Continuous single requester:
   - Stimulus: requester 1 holds `req` high permanently, b1=10, a1 incremented after each grant.
   - Required response: `grant`=0010 every 2 cycles and `res_valid` every 2 cycles, with correct products in order.

Source files
------------

// File: rtl/boothmul_arbiter_if.sv
// Handshake bundle between up to four multiply clients and the
// shared Booth multiplier sequencer.
//   req       : per-requester request level
//   a_in/b_in : flattened signed operands, requester i at [8i+7:8i]
//   grant     : one-hot capture pulse
//   busy      : multiply in flight
//   res_valid : one-cycle result strobe
//   res/res_id: signed product and owning requester index
interface boothmul_arbiter_if #(
  parameter int N_REQ = 4
) ();
  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] a_in;
  logic [8*N_REQ-1:0] b_in;
  logic [N_REQ-1:0]   grant;
  logic               busy;
  logic               res_valid;
  logic [15:0]        res;
  logic [1:0]         res_id;

  modport master (
    output req, a_in, b_in,
    input  grant, busy, res_valid, res, res_id
  );

  modport slave (
    input  req, a_in, b_in,
    output grant, busy, res_valid, res, res_id
  );
endinterface

// File: rtl/boothmul_arbiter.sv
// Round-robin sequencer sharing one 8x8 signed radix-4 Booth
// multiplier among up to four requesters.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : slave side of boothmul_arbiter_if (req/a_in/b_in in,
//         grant/busy/res_valid/res/res_id out, all registered)
module boothmul (
  input  logic signed [7:0]  i_a,
  input  logic signed [7:0]  i_b,
  output logic signed [15:0] o_p
);
  logic signed [15:0] w_a16;
  logic signed [15:0] w_pp;
  logic signed [15:0] w_acc;
  logic [8:0]         w_bx;
  logic [2:0]         w_trip;

  always_comb begin
    w_a16  = {{8{i_a[7]}}, i_a};
    w_bx   = {i_b, 1'b0};
    w_acc  = '0;
    w_pp   = '0;
    w_trip = '0;
    // Radix-4 recoding: each bit triple selects 0, +-a or +-2a.
    for (int j = 0; j < 4; j++) begin
      w_trip = w_bx[2*j +: 3];
      case (w_trip)
        3'b001, 3'b010: w_pp = w_a16;
        3'b011:         w_pp = w_a16 <<< 1;
        3'b100:         w_pp = -(w_a16 <<< 1);
        3'b101, 3'b110: w_pp = -w_a16;
        default:        w_pp = '0;
      endcase
      w_acc = w_acc + (w_pp <<< (2*j));
    end
    o_p = w_acc;
  end
endmodule

module boothmul_arbiter #(
  parameter int N_REQ = 4
) (
  input logic               clk,
  input logic               rst,
  boothmul_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [1:0]       r_last;
  logic [1:0]       r_cur;
  logic [7:0]       r_op_a;
  logic [7:0]       r_op_b;
  logic [N_REQ-1:0] r_grant;
  logic             r_busy;
  logic             r_rv;
  logic [15:0]      r_res;
  logic [1:0]       r_res_id;

  logic [1:0]         w_win;
  logic [2:0]         w_sum;
  logic [1:0]         w_idx;
  logic [N_REQ-1:0]   w_rot;
  logic               w_any;
  logic [7:0]         w_a;
  logic [7:0]         w_b;
  logic [N_REQ-1:0]   w_onehot;
  logic signed [15:0] w_prod;

  // Walk from the farthest candidate back to last+1 so the
  // nearest requesting index after last wins.
  always_comb begin
    w_any = |bus.req;
    w_win = r_last;
    w_sum = '0;
    w_idx = '0;
    w_rot = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      w_sum = {1'b0, r_last} + 3'(k);
      if (w_sum >= 3'(N_REQ))
        w_sum = w_sum - 3'(N_REQ);
      w_idx = w_sum[1:0];
      w_rot = bus.req >> w_idx;
      if (w_rot[0])
        w_win = w_idx;
    end
    w_a      = 8'(bus.a_in >> {w_win, 3'b000});
    w_b      = 8'(bus.b_in >> {w_win, 3'b000});
    w_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << w_win;
  end

  boothmul u_mul (
    .i_a (r_op_a),
    .i_b (r_op_b),
    .o_p (w_prod)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_last   <= 2'(N_REQ-1);
      r_cur    <= '0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_grant  <= '0;
      r_busy   <= 1'b0;
      r_rv     <= 1'b0;
      r_res    <= '0;
      r_res_id <= '0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          r_rv <= 1'b0;
          if (w_any) begin
            r_state <= S_CALC;
            r_op_a  <= w_a;
            r_op_b  <= w_b;
            r_grant <= w_onehot;
            r_busy  <= 1'b1;
            r_last  <= w_win;
            r_cur   <= w_win;
          end else begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_busy  <= 1'b0;
          end
        end
        S_CALC: begin
          r_state  <= S_DONE;
          r_res    <= w_prod;
          r_res_id <= r_cur;
          r_rv     <= 1'b1;
          r_grant  <= '0;
          r_busy   <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.grant     = r_grant;
  assign bus.busy      = r_busy;
  assign bus.res_valid = r_rv;
  assign bus.res       = r_res;
  assign bus.res_id    = r_res_id;
endmodule
